stage_ctrl_fsm: RTL
===================

// Module: stage_ctrl_fsm
// PURPOSE
//  Parametrised multicycle stage controller; successor to the fixed 4-stage IF/EXST/MEM/SEND controller.
//  Sequences IF -> EXST -> {MEM | SEND | HALT} -> IF and drives the datapath write enables.
//  Adds a variable-latency MEM stage (fixed count or ready handshake), an optional UART send timeout and a HALT/run stage.
// PARAMETERS
//  MEM_LAT      1   MEM cycles when USE_MEM_RDY=0; legal 1..2**CNT_W-1
//  USE_MEM_RDY  0   1: MEM ends on mem_ready; MEM_LAT ignored
//  TX_TIMEOUT   0   max SEND cycles before forced exit; 0 = no timeout; legal 0..2**CNT_W-1
//  CNT_W        8   wait-counter width
// PORTS
//  clk            in   1  clock, rising edge
//  resetn         in   1  reset, asynchronous, active-low
//  mem_inst       in   1  EXST: current instruction needs MEM
//  mem_force      in   1  final MEM cycle: return to EXST (multi-access instruction)
//  send_inst      in   1  EXST: current instruction is a UART send
//  halt_inst      in   1  EXST: current instruction is HALT
//  mem_ready      in   1  memory done (USE_MEM_RDY=1 only)
//  uart_te        in   1  UART transmitter empty
//  run            in   1  resume from HALT
//  exst_to_mem_wen out 1  latch EXST results for MEM
//  ir_wen, pc_wen, psr_wen, rf_wen, st_wen  out 1 each  datapath write enables
//  uart_load      out  1  load UART TX buffer
//  tx_timeout     out  1  one-cycle pulse: SEND aborted by timeout
//  stage          out  3  current stage encoding
// BEHAVIOUR
//  - Stage register, encoding IF=0 EXST=1 MEM=2 SEND=3 HALT=4. Reset: stage=IF, counter=0.
//  - While resetn=0 every output is 0 (enables gated by resetn). Unused codes 5..7 -> IF next cycle, enables 0.
//  - Enables are combinational from stage + inputs, same cycle.
//  - IF: ir_wen=1, all other enables 0; next EXST.
//  - EXST, priority mem_inst > send_inst > halt_inst > normal:
//    mem:  exst_to_mem_wen=1, rest 0; next MEM.
//    send: pc/psr/rf/st_wen=1, uart_load=1; next SEND.
//    halt: pc/psr/rf/st_wen=1; next HALT.
//    else: pc/psr/rf/st_wen=1; next IF.
//  - Counter clears on every stage entry and increments each cycle spent in MEM or SEND. Saturates; never wraps.
//  - MEM final cycle: USE_MEM_RDY=1 -> mem_ready=1; else counter==MEM_LAT-1. MEM_LAT=1 gives a single-cycle MEM.
//    In non-final cycles all enables are 0.
//    Final cycle: rf_wen=st_wen=1; pc_wen=~mem_force; next EXST if mem_force else IF.
//  - SEND: all enables 0. Exit to IF when uart_te=1.
//    Else if TX_TIMEOUT!=0 and counter==TX_TIMEOUT-1: exit to IF with tx_timeout=1 for that cycle.
//    uart_te=1 on the same cycle as the timeout wins; no pulse.
//  - HALT: all enables 0; stay until run=1, then IF. run is ignored outside HALT.
//  - Reset mid-stage aborts immediately: no enable is asserted during or after reset until IF.
// STRUCTURE
//  - Shared package stage_pkg: STG_IF..STG_HALT localparams, STG_W=3.
//  - One sub-module, stage_wait_cnt (CNT_W): clear, enable, saturating count, compare-to-limit output.
//    Used for both MEM latency and SEND timeout.
// TESTING
//  1 MEM_LAT=1, mem_inst=1 in EXST -> IF,EXST,MEM,IF. exst_to_mem_wen in EXST; rf/st/pc_wen in MEM.
//  2 MEM_LAT=3, mem_force=1 on final MEM -> 3 MEM cycles, enables 0 in first two, pc_wen=0 in third, then EXST.
//  3 USE_MEM_RDY=1, mem_ready after 5 cycles -> stays MEM 5 cycles; enables fire only on the mem_ready cycle.
//  4 TX_TIMEOUT=4, uart_te held 0 -> 4 SEND cycles, tx_timeout pulse on the 4th, then IF. Repeat with uart_te=1 on cycle 4 -> no pulse.
//  5 halt_inst in EXST, run=1 after 10 cycles -> stage=4 for 10 cycles, all enables 0, then IF.
//  6 resetn low in cycle 2 of MEM (MEM_LAT=3) -> outputs 0 at once; after release stage=IF, ir_wen=1.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared stage encodings and enable bundle for the multicycle stage controller.
package stage_pkg;

    localparam int STG_W = 3;

    localparam logic [STG_W-1:0] STG_IF   = 3'd0;
    localparam logic [STG_W-1:0] STG_EXST = 3'd1;
    localparam logic [STG_W-1:0] STG_MEM  = 3'd2;
    localparam logic [STG_W-1:0] STG_SEND = 3'd3;
    localparam logic [STG_W-1:0] STG_HALT = 3'd4;

    typedef enum logic [STG_W-1:0] {
        S_IF   = STG_IF,
        S_EXST = STG_EXST,
        S_MEM  = STG_MEM,
        S_SEND = STG_SEND,
        S_HALT = STG_HALT
    } stage_e;

    typedef struct packed {
        logic exst_to_mem_wen;
        logic ir_wen;
        logic pc_wen;
        logic psr_wen;
        logic rf_wen;
        logic st_wen;
        logic uart_load;
        logic tx_timeout;
    } stage_en_t;

    // Stages whose duration is measured by the wait counter
    function automatic logic stg_is_wait(input stage_e stg);
        return (stg == S_MEM) || (stg == S_SEND);
    endfunction

endpackage

// File: rtl/stage_ctrl_fsm_if.sv
// Instruction-decode inputs and datapath-enable outputs of the stage controller.
interface stage_ctrl_fsm_if;

    logic                        mem_inst;
    logic                        mem_force;
    logic                        send_inst;
    logic                        halt_inst;
    logic                        mem_ready;
    logic                        uart_te;
    logic                        run;

    logic                        exst_to_mem_wen;
    logic                        ir_wen;
    logic                        pc_wen;
    logic                        psr_wen;
    logic                        rf_wen;
    logic                        st_wen;
    logic                        uart_load;
    logic                        tx_timeout;
    logic [stage_pkg::STG_W-1:0] stage;

    modport master (
        output mem_inst, mem_force, send_inst, halt_inst, mem_ready, uart_te, run,
        input  exst_to_mem_wen, ir_wen, pc_wen, psr_wen, rf_wen, st_wen,
        input  uart_load, tx_timeout, stage
    );

    modport slave (
        input  mem_inst, mem_force, send_inst, halt_inst, mem_ready, uart_te, run,
        output exst_to_mem_wen, ir_wen, pc_wen, psr_wen, rf_wen, st_wen,
        output uart_load, tx_timeout, stage
    );

endinterface

// File: rtl/stage_ctrl_fsm_wait_cnt.sv
// Saturating wait counter shared by the MEM latency and SEND timeout checks.
module stage_wait_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    // Count cycles in the current stage; holds at all-ones instead of wrapping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_hit = (r_cnt == i_limit);

endmodule

// File: rtl/stage_ctrl_fsm.sv
// Multicycle stage controller: IF -> EXST -> {MEM | SEND | HALT} -> IF with a
// variable-latency MEM stage and an optional SEND timeout.
module stage_ctrl_fsm
    import stage_pkg::*;
#(
    parameter int MEM_LAT     = 1,
    parameter int USE_MEM_RDY = 0,
    parameter int TX_TIMEOUT  = 0,
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            resetn,
    stage_ctrl_fsm_if.slave io_ctl
);

    localparam logic [CNT_W-1:0] MEM_LIMIT   = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT   = CNT_W'(TX_TIMEOUT - 1);
    localparam bit               HAS_TIMEOUT = (TX_TIMEOUT != 0);
    localparam bit               MEM_BY_RDY  = (USE_MEM_RDY != 0);

    stage_e           r_stage;
    stage_e           w_stage_nxt;
    stage_en_t        w_en;
    logic [CNT_W-1:0] w_limit;
    logic             w_cnt_hit;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_mem_final;

    // Stage register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stage <= S_IF;
        end else begin
            r_stage <= w_stage_nxt;
        end
    end

    // Next-stage selection and same-cycle datapath enables
    always_comb begin
        w_stage_nxt = S_IF;
        w_en        = '0;
        w_mem_final = MEM_BY_RDY ? io_ctl.mem_ready : w_cnt_hit;
        case (r_stage)
            S_IF: begin
                w_en.ir_wen = 1'b1;
                w_stage_nxt = S_EXST;
            end
            S_EXST: begin
                if (io_ctl.mem_inst) begin
                    w_en.exst_to_mem_wen = 1'b1;
                    w_stage_nxt          = S_MEM;
                end else begin
                    w_en.pc_wen    = 1'b1;
                    w_en.psr_wen   = 1'b1;
                    w_en.rf_wen    = 1'b1;
                    w_en.st_wen    = 1'b1;
                    w_en.uart_load = io_ctl.send_inst;
                    if (io_ctl.send_inst) begin
                        w_stage_nxt = S_SEND;
                    end else if (io_ctl.halt_inst) begin
                        w_stage_nxt = S_HALT;
                    end else begin
                        w_stage_nxt = S_IF;
                    end
                end
            end
            S_MEM: begin
                if (w_mem_final) begin
                    w_en.rf_wen = 1'b1;
                    w_en.st_wen = 1'b1;
                    w_en.pc_wen = ~io_ctl.mem_force;
                    w_stage_nxt = io_ctl.mem_force ? S_EXST : S_IF;
                end else begin
                    w_stage_nxt = S_MEM;
                end
            end
            S_SEND: begin
                // Transmitter-empty takes precedence over a coincident timeout
                if (io_ctl.uart_te) begin
                    w_stage_nxt = S_IF;
                end else if (HAS_TIMEOUT && w_cnt_hit) begin
                    w_en.tx_timeout = 1'b1;
                    w_stage_nxt     = S_IF;
                end else begin
                    w_stage_nxt = S_SEND;
                end
            end
            S_HALT: begin
                if (io_ctl.run) begin
                    w_stage_nxt = S_IF;
                end else begin
                    w_stage_nxt = S_HALT;
                end
            end
            default: begin
                w_stage_nxt = S_IF;
            end
        endcase
    end

    assign w_limit   = (r_stage == S_SEND) ? TMO_LIMIT : MEM_LIMIT;
    assign w_cnt_en  = stg_is_wait(r_stage);
    assign w_cnt_clr = (w_stage_nxt != r_stage);

    stage_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_limit (w_limit),
        .o_hit   (w_cnt_hit)
    );

    // Gating with resetn makes a mid-stage reset silence the datapath immediately
    assign io_ctl.exst_to_mem_wen = resetn & w_en.exst_to_mem_wen;
    assign io_ctl.ir_wen          = resetn & w_en.ir_wen;
    assign io_ctl.pc_wen          = resetn & w_en.pc_wen;
    assign io_ctl.psr_wen         = resetn & w_en.psr_wen;
    assign io_ctl.rf_wen          = resetn & w_en.rf_wen;
    assign io_ctl.st_wen          = resetn & w_en.st_wen;
    assign io_ctl.uart_load       = resetn & w_en.uart_load;
    assign io_ctl.tx_timeout      = resetn & w_en.tx_timeout;
    assign io_ctl.stage           = r_stage;

endmodule
